// File: rtl/nids_csr_queue_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : nids_csr_queue_bridge_if
// Purpose  : Avalon-MM slave bus bundle for the NIDS CSR/queue bridge.
//            Fixed 10-bit byte address and 32-bit data.
// Revision : 1.0 - initial release
// ============================================================================
interface nids_csr_queue_bridge_if;
  logic [9:0]  avs_address;
  logic        avs_write;
  logic        avs_read;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_write, avs_read, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_write, avs_read, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/nids_csr_queue_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nids_csr_queue_bridge
// Purpose  : CSR front end for a NIDS scoring pipeline. Software loads the
//            feature words, triggers a packet, and collects results from a
//            small FIFO. Optional interrupt is enabled by defining the macro
//            NIDS_BRIDGE_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nids_csr_queue_bridge #(
  parameter int NUM_FEATURES = 28,
  parameter int DATA_W       = 32,
  parameter int RES_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  nids_csr_queue_bridge_if.slave         avs,
  output logic [NUM_FEATURES*DATA_W-1:0] pkt_features,
  output logic                           pkt_valid,
  input  logic                           attack_detected,
  input  logic [DATA_W-1:0]              major_score,
  input  logic [DATA_W-1:0]              minor_score,
  input  logic                           valid_out,
  output logic                           irq
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;

  localparam logic [9:0] c_addr_control = 10'h200;
  localparam logic [9:0] c_addr_status  = 10'h204;
  localparam logic [9:0] c_addr_attack  = 10'h208;
  localparam logic [9:0] c_addr_major   = 10'h20C;
  localparam logic [9:0] c_addr_minor   = 10'h210;
  localparam logic [9:0] c_addr_timeout = 10'h214;
  localparam logic [9:0] c_addr_irq_en  = 10'h218;

  logic [1:0]                     r_state;
  logic [NUM_FEATURES*DATA_W-1:0] r_features;
  logic [NUM_FEATURES*DATA_W-1:0] r_pkt_features;
  logic [15:0]                    r_timeout;
  logic [15:0]                    r_wait_cnt;
  logic                           r_overflow;
  logic                           r_timeout_flag;
  logic                           r_trig_dropped;
  logic [31:0]                    r_readdata;

  logic                           r_mem_attack [RES_DEPTH];
  logic [DATA_W-1:0]              r_mem_major  [RES_DEPTH];
  logic [DATA_W-1:0]              r_mem_minor  [RES_DEPTH];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_count;

  logic        w_aligned;
  logic        w_feat_sel;
  logic [6:0]  w_feat_idx;
  logic        w_wr_feat;
  logic        w_wr_ctrl;
  logic        w_trigger;
  logic        w_clear;
  logic        w_flush;
  logic        w_busy;
  logic        w_q_empty;
  logic        w_q_full;
  logic        w_push;
  logic        w_pop;
  logic        w_do_push;
  logic        w_overflow_evt;
  logic        w_timeout_hit;
  logic [31:0] w_rdata;

  // Address decode: low two byte-address bits must be zero for any hit.
  assign w_aligned  = (avs.avs_address[1:0] == 2'b00);
  assign w_feat_sel = ~avs.avs_address[9] & w_aligned;
  assign w_feat_idx = avs.avs_address[8:2];
  assign w_wr_feat  = avs.avs_write & w_feat_sel;
  assign w_wr_ctrl  = avs.avs_write & (avs.avs_address == c_addr_control);
  assign w_trigger  = w_wr_ctrl & avs.avs_writedata[0];
  assign w_clear    = w_wr_ctrl & avs.avs_writedata[1];
  assign w_flush    = w_wr_ctrl & avs.avs_writedata[2];

  assign w_busy    = (r_state != c_st_idle);
  assign w_q_empty = (r_count == '0);
  assign w_q_full  = (r_count == CNT_W'(RES_DEPTH));

  // A RES_MINOR read consumes the head entry.
  assign w_pop  = avs.avs_read & (avs.avs_address == c_addr_minor) & ~w_q_empty;
  assign w_push = (r_state == c_st_wait) & valid_out;
  assign w_do_push      = w_push & (~w_q_full | w_pop);
  assign w_overflow_evt = w_push & w_q_full & ~w_pop & ~w_flush;

  assign w_timeout_hit = (r_state == c_st_wait) & ~valid_out & (r_timeout != 16'd0) &
                         ((r_wait_cnt + 16'd1) == r_timeout);

  assign pkt_features        = r_pkt_features;
  assign pkt_valid           = (r_state == c_st_issue);
  assign avs.avs_waitrequest = 1'b0;
  assign avs.avs_readdata    = r_readdata;

  // Software-writable configuration: feature words and timeout limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_features <= '0;
      r_timeout  <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_FEATURES; i++) begin
        if (w_wr_feat && (32'(w_feat_idx) == i))
          r_features[i*DATA_W +: DATA_W] <= DATA_W'(avs.avs_writedata);
      end
      if (avs.avs_write && (avs.avs_address == c_addr_timeout))
        r_timeout <= avs.avs_writedata[15:0];
    end
  end

  // Packet FSM: snapshot features on trigger, pulse for one cycle, then wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= c_st_idle;
      r_pkt_features <= '0;
      r_wait_cnt     <= 16'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_trigger) begin
            r_state        <= c_st_issue;
            r_pkt_features <= r_features;
          end
        end
        c_st_issue: begin
          r_state    <= c_st_wait;
          r_wait_cnt <= 16'd0;
        end
        c_st_wait: begin
          if (valid_out || w_timeout_hit)
            r_state <= c_st_idle;
          else
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Sticky status bits; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow     <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_trig_dropped <= 1'b0;
    end else begin
      if (w_clear) begin
        r_overflow     <= 1'b0;
        r_timeout_flag <= 1'b0;
        r_trig_dropped <= 1'b0;
      end
      if (w_overflow_evt)
        r_overflow <= 1'b1;
      if (w_timeout_hit)
        r_timeout_flag <= 1'b1;
      if (w_trigger && w_busy)
        r_trig_dropped <= 1'b1;
    end
  end

  // Result FIFO; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        r_mem_attack[i] <= 1'b0;
        r_mem_major[i]  <= '0;
        r_mem_minor[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem_attack[r_wr_ptr] <= attack_detected;
        r_mem_major[r_wr_ptr]  <= major_score;
        r_mem_minor[r_wr_ptr]  <= minor_score;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef NIDS_BRIDGE_IRQ_EN
  logic r_irq_en;

  // Interrupt enable register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_irq_en <= 1'b0;
    else if (avs.avs_write && (avs.avs_address == c_addr_irq_en))
      r_irq_en <= avs.avs_writedata[0];
  end

  assign irq = r_irq_en & (~w_q_empty | r_timeout_flag | r_overflow);
`else
  assign irq = 1'b0;
`endif

  // Read-data mux; queue head reads return zero when the queue is empty.
  always_comb begin
    w_rdata = 32'd0;
    if (w_feat_sel) begin
      for (int i = 0; i < NUM_FEATURES; i++) begin
        if (32'(w_feat_idx) == i)
          w_rdata = 32'(r_features[i*DATA_W +: DATA_W]);
      end
    end else begin
      case (avs.avs_address)
        c_addr_status: begin
          w_rdata[12:8] = 5'(r_count);
          w_rdata[5:0]  = {r_trig_dropped, r_timeout_flag, r_overflow,
                           w_q_full, w_q_empty, w_busy};
        end
        c_addr_attack:  w_rdata[0] = ~w_q_empty & r_mem_attack[r_rd_ptr];
        c_addr_major:   w_rdata = w_q_empty ? 32'd0 : 32'(r_mem_major[r_rd_ptr]);
        c_addr_minor:   w_rdata = w_q_empty ? 32'd0 : 32'(r_mem_minor[r_rd_ptr]);
        c_addr_timeout: w_rdata[15:0] = r_timeout;
`ifdef NIDS_BRIDGE_IRQ_EN
        c_addr_irq_en:  w_rdata[0] = r_irq_en;
`endif
        default:        w_rdata = 32'd0;
      endcase
    end
  end

  // Read data is registered on a read strobe and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_readdata <= 32'd0;
    else if (avs.avs_read)
      r_readdata <= w_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_nids_csr_queue_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nids_csr_queue_bridge
// Purpose  : Directed self-checking bench for nids_csr_queue_bridge with a
//            result scoreboard. Honours NIDS_BRIDGE_IRQ_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nids_csr_queue_bridge;

  localparam int NF = 28;
  localparam int DW = 32;
  localparam int RD = 4;

  localparam logic [9:0] A_CONTROL = 10'h200;
  localparam logic [9:0] A_STATUS  = 10'h204;
  localparam logic [9:0] A_ATTACK  = 10'h208;
  localparam logic [9:0] A_MAJOR   = 10'h20C;
  localparam logic [9:0] A_MINOR   = 10'h210;
  localparam logic [9:0] A_TIMEOUT = 10'h214;
  localparam logic [9:0] A_IRQ_EN  = 10'h218;

  typedef struct packed {
    logic        attack;
    logic [31:0] major;
    logic [31:0] minor;
  } res_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NF*DW-1:0]  pkt_features;
  logic              pkt_valid;
  logic              attack_detected;
  logic [DW-1:0]     major_score;
  logic [DW-1:0]     minor_score;
  logic              valid_out;
  logic              irq;

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;

  nids_csr_queue_bridge_if bus();

  nids_csr_queue_bridge #(
    .NUM_FEATURES (NF),
    .DATA_W       (DW),
    .RES_DEPTH    (RD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs             (bus.slave),
    .pkt_features    (pkt_features),
    .pkt_valid       (pkt_valid),
    .attack_detected (attack_detected),
    .major_score     (major_score),
    .minor_score     (minor_score),
    .valid_out       (valid_out),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // Count packet pulses, sampled away from the active edge.
  always @(negedge clk) if (pkt_valid) pulses++;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    check(tag, bus.avs_readdata, exp);
  endtask

  // Trigger one packet and answer it one cycle into WAIT.
  task automatic run_packet(input logic a, input logic [31:0] mj, input logic [31:0] mn);
    res_t e;
    bus_write(A_CONTROL, 32'h1);
    @(negedge clk);
    attack_detected = a;
    major_score     = mj;
    minor_score     = mn;
    valid_out       = 1'b1;
    @(negedge clk);
    valid_out       = 1'b0;
    e.attack = a;
    e.major  = mj;
    e.minor  = mn;
    if (sb.size() < RD) sb.push_back(e);
  endtask

  // Read the three head registers; the RES_MINOR read pops.
  task automatic pop_check(input string tag);
    res_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    read_check({tag, "_attack"}, A_ATTACK, {31'b0, e.attack});
    read_check({tag, "_major"},  A_MAJOR,  e.major);
    read_check({tag, "_minor"},  A_MINOR,  e.minor);
  endtask

  initial begin
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    bus.avs_writedata = '0;
    attack_detected   = 1'b0;
    major_score       = '0;
    minor_score       = '0;
    valid_out         = 1'b0;
    reset_n           = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("rst_pkt_valid", {31'b0, pkt_valid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_features_zero", {31'b0, (pkt_features == '0)}, 32'h1);
    check("rst_readdata", bus.avs_readdata, 32'h0);
    check("rst_waitrequest", {31'b0, bus.avs_waitrequest}, 32'h0);
    read_check("rst_status", A_STATUS, 32'h0000_0002);
    read_check("rst_timeout", A_TIMEOUT, 32'h0);

    // Feature load and readback, plus map boundaries
    bus_write(10'h000, 32'h0000_00A5);
    bus_write(10'h06C, 32'h0000_1234);
    bus_write(10'h070, 32'hDEAD_BEEF);
    read_check("feat27_rd", 10'h06C, 32'h0000_1234);
    read_check("feat28_unmapped", 10'h070, 32'h0);
    read_check("unmapped_21c", 10'h21C, 32'h0);
    read_check("control_reads0", A_CONTROL, 32'h0);

    // Trigger: one-cycle pulse carrying the snapshot
    bus_write(A_CONTROL, 32'h1);
    check("issue_pkt_valid", {31'b0, pkt_valid}, 32'h1);
    check("issue_feat0", pkt_features[0 +: 32], 32'h0000_00A5);
    check("issue_feat27", pkt_features[27*32 +: 32], 32'h0000_1234);
    check("issue_feat1", pkt_features[1*32 +: 32], 32'h0);
    @(negedge clk);
    check("wait_pkt_valid", {31'b0, pkt_valid}, 32'h0);
    read_check("wait_status_busy", A_STATUS, 32'h0000_0003);
    bus_write(10'h000, 32'h0000_0055);
    check("busy_write_no_effect", pkt_features[0 +: 32], 32'h0000_00A5);

    // Complete with a result
    attack_detected = 1'b1;
    major_score     = 32'd7;
    minor_score     = 32'd3;
    valid_out       = 1'b1;
    @(negedge clk);
    valid_out       = 1'b0;
    sb.push_back('{attack: 1'b1, major: 32'd7, minor: 32'd3});
    read_check("done_status", A_STATUS, 32'h0000_0100);
    pop_check("res1");
    read_check("after_pop_status", A_STATUS, 32'h0000_0002);

    // valid_out while idle is ignored
    valid_out = 1'b1;
    @(negedge clk);
    valid_out = 1'b0;
    read_check("idle_valid_ignored", A_STATUS, 32'h0000_0002);

    // Overflow: RD+1 results, first RD retained
    for (int k = 0; k < RD + 1; k++)
      run_packet(k[0], 32'h100 + 32'(k), 32'h200 + 32'(k));
    check("next_pkt_new_feat0", pkt_features[0 +: 32], 32'h0000_0055);
    read_check("ovf_status", A_STATUS, 32'h0000_040C);
    for (int k = 0; k < RD; k++) pop_check("ovf_res");
    read_check("empty_minor_zero", A_MINOR, 32'h0);
    read_check("ovf_sticky_status", A_STATUS, 32'h0000_000A);
    bus_write(A_CONTROL, 32'h2);
    read_check("ovf_cleared", A_STATUS, 32'h0000_0002);

    // Flush
    run_packet(1'b1, 32'hAA, 32'hBB);
    run_packet(1'b0, 32'hCC, 32'hDD);
    read_check("preflush_status", A_STATUS, 32'h0000_0200);
    bus_write(A_CONTROL, 32'h4);
    sb.delete();
    read_check("flush_status", A_STATUS, 32'h0000_0002);

    // Timeout of 10 cycles after WAIT entry
    bus_write(A_TIMEOUT, 32'h0001_000A);
    read_check("timeout_rd", A_TIMEOUT, 32'h0000_000A);
    bus_write(A_CONTROL, 32'h1);
    repeat (9) @(negedge clk);
    read_check("to_cycle10_busy", A_STATUS, 32'h0000_0003);
    read_check("to_expired", A_STATUS, 32'h0000_0012);
    bus_write(A_CONTROL, 32'h2);
    read_check("to_cleared", A_STATUS, 32'h0000_0002);
    bus_write(A_TIMEOUT, 32'h0);

    // Back-to-back trigger: second one dropped
    begin
      int p0;
      p0 = pulses;
      @(negedge clk);
      bus.avs_address   = A_CONTROL;
      bus.avs_writedata = 32'h1;
      bus.avs_write     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.avs_write     = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_one_pulse", 32'(pulses - p0), 32'd1);
    end
    read_check("b2b_dropped", A_STATUS, 32'h0000_0023);
    attack_detected = 1'b0;
    major_score     = 32'h9;
    minor_score     = 32'h8;
    valid_out       = 1'b1;
    @(negedge clk);
    valid_out       = 1'b0;
    sb.push_back('{attack: 1'b0, major: 32'h9, minor: 32'h8});
    pop_check("b2b_res");
    bus_write(A_CONTROL, 32'h2);
    read_check("b2b_cleared", A_STATUS, 32'h0000_0002);

    // Interrupt
    bus_write(A_IRQ_EN, 32'h1);
`ifdef NIDS_BRIDGE_IRQ_EN
    read_check("irq_en_rd", A_IRQ_EN, 32'h1);
    check("irq_idle", {31'b0, irq}, 32'h0);
    run_packet(1'b1, 32'h5, 32'h6);
    check("irq_pending", {31'b0, irq}, 32'h1);
    pop_check("irq_res");
    check("irq_cleared", {31'b0, irq}, 32'h0);
`else
    read_check("irq_en_rd0", A_IRQ_EN, 32'h0);
    run_packet(1'b1, 32'h5, 32'h6);
    check("irq_tied0", {31'b0, irq}, 32'h0);
    pop_check("irq_res");
`endif

    // Reset mid-WAIT discards the outstanding packet
    bus_write(A_TIMEOUT, 32'h55);
    bus_write(A_CONTROL, 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst2_readdata", bus.avs_readdata, 32'h0);
    check("rst2_features_zero", {31'b0, (pkt_features == '0)}, 32'h1);
    valid_out = 1'b1;
    @(negedge clk);
    valid_out = 1'b0;
    read_check("rst2_status", A_STATUS, 32'h0000_0002);
    read_check("rst2_timeout", A_TIMEOUT, 32'h0);
    read_check("rst2_feat27", 10'h06C, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
